// File: rtl/cos_angle_reducer.sv
// Reduces an unsigned integer angle in degrees to the first quadrant for a
// cosine evaluation. The result is x_deg in 0..90 as an IEEE-754 single and a
// sign flag so that cos(angle) = (neg ? -1 : 1) * cos(x_deg).
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   angle, in_valid    input angle in integer degrees (ANGLE_W bits, ANGLE_W >= 9)
//   in_ready           high only while idle; an angle is accepted on in_valid & in_ready
//   x_deg, neg         reduced angle (float32) and cosine sign flag
//   out_valid          result valid; held stable until out_ready
//   out_ready          downstream accepts the result
module cos_angle_reducer #(
  parameter int unsigned ANGLE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        x_deg,
  output logic               neg,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REDUCE = 3'd1;
  localparam logic [2:0] FOLD   = 3'd2;
  localparam logic [2:0] NORM   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int unsigned R_W   = 7;
  localparam int unsigned EXP_W = 8;

  localparam logic [ANGLE_W-1:0] FULL_TURN = ANGLE_W'(360);
  // Biased exponent for a value whose leading one sits at bit 6 (64..127).
  localparam logic [EXP_W-1:0]   EXP_INIT  = EXP_W'(133);

  logic [2:0]         state, state_nxt;
  logic [ANGLE_W-1:0] d, d_nxt;
  logic [R_W-1:0]     r, r_nxt;
  logic [EXP_W-1:0]   exp_q, exp_nxt;
  logic [31:0]        x_nxt;
  logic               neg_nxt;
  logic [8:0]         d9;

  // After REDUCE the remainder is below 360, so 9 bits hold it exactly.
  assign d9 = 9'(d);

  // Next-state and datapath next values.
  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    r_nxt     = r;
    exp_nxt   = exp_q;
    x_nxt     = x_deg;
    neg_nxt   = neg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          d_nxt     = angle;
          state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        // One subtraction per cycle; never underflows since d >= 360 here.
        if (d >= FULL_TURN) begin
          d_nxt = d - FULL_TURN;
        end else begin
          state_nxt = FOLD;
        end
      end
      FOLD: begin
        if (d9 <= 9'd90) begin
          r_nxt   = R_W'(d9);
          neg_nxt = 1'b0;
        end else if (d9 <= 9'd180) begin
          r_nxt   = R_W'(9'd180 - d9);
          neg_nxt = 1'b1;
        end else if (d9 <= 9'd270) begin
          r_nxt   = R_W'(d9 - 9'd180);
          neg_nxt = 1'b1;
        end else begin
          r_nxt   = R_W'(9'd360 - d9);
          neg_nxt = 1'b0;
        end
        exp_nxt   = EXP_INIT;
        state_nxt = NORM;
      end
      NORM: begin
        // Left-justify r; the leading one becomes the implicit mantissa bit.
        if (r == '0) begin
          x_nxt     = 32'h0000_0000;
          state_nxt = DONE;
        end else if (r[R_W-1]) begin
          x_nxt     = {1'b0, exp_q, r[R_W-2:0], 17'b0};
          state_nxt = DONE;
        end else begin
          r_nxt   = {r[R_W-2:0], 1'b0};
          exp_nxt = exp_q - EXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d         <= '0;
      r         <= '0;
      exp_q     <= '0;
      x_deg     <= 32'h0000_0000;
      neg       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      d         <= d_nxt;
      r         <= r_nxt;
      exp_q     <= exp_nxt;
      x_deg     <= x_nxt;
      neg       <= neg_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_cos_angle_reducer.sv
// Scoreboard bench for cos_angle_reducer: a driver issues angles and pushes
// reference results; a monitor applies random back-pressure and checks outputs.
module tb_cos_angle_reducer;

  localparam int unsigned ANGLE_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [ANGLE_W-1:0] angle;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        x_deg;
  logic               neg;
  logic               out_valid;
  logic               out_ready;

  always #5 clk = ~clk;

  cos_angle_reducer #(.ANGLE_W(ANGLE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .angle    (angle),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_deg    (x_deg),
    .neg      (neg),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] x;
    logic        sgn;
    int          lat;
    int          acc;
    int unsigned a;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: reduce modulo 360, fold to the first quadrant, build the float
  // from the leading-one position directly.
  function automatic exp_t model(input int unsigned a, input int acc);
    exp_t e;
    int unsigned k, d, r, m;
    logic [7:0]  ex;
    logic [22:0] man;
    k = a / 360;
    d = a % 360;
    if (d <= 90)       begin r = d;       e.sgn = 1'b0; end
    else if (d <= 180) begin r = 180 - d; e.sgn = 1'b1; end
    else if (d <= 270) begin r = d - 180; e.sgn = 1'b1; end
    else               begin r = 360 - d; e.sgn = 1'b0; end
    if (r == 0) begin
      e.x   = 32'h0;
      e.lat = int'(k) + 3;
    end else begin
      m = 0;
      for (int b = 0; b < 7; b++) if (r >= (32'd1 << b)) m = b;
      ex    = 8'(127 + m);
      man   = 23'((r - (32'd1 << m)) << (23 - m));
      e.x   = {1'b0, ex, man};
      e.lat = int'(k) + 3 + 6 - int'(m);
    end
    e.acc = acc;
    e.a   = a;
    return e;
  endfunction

  // Waits for in_ready (sprinkling ignored in_valid pulses), then offers one angle.
  task automatic send(input int unsigned a, input bit push);
    int t;
    t = 0;
    while (!in_ready && t < 2000) begin
      in_valid = 1'b1 & 1'($urandom_range(0, 1));
      angle    = ANGLE_W'($urandom);
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    angle    = ANGLE_W'(a);
    if (push) sb.push_back(model(a, cyc + 1));
    @(negedge clk);
    in_valid = 1'b0;
    angle    = ANGLE_W'($urandom);
  endtask

  // Monitor: back-pressure, latency, value and hold checks.
  initial begin : monitor
    bit   prev_valid;
    bit   accepted_last;
    bit   hold_used;
    int   hold_left;
    exp_t cur;
    prev_valid    = 1'b0;
    accepted_last = 1'b0;
    hold_used     = 1'b0;
    hold_left     = 0;
    out_ready     = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid    = 1'b0;
        accepted_last = 1'b0;
        continue;
      end
      if (accepted_last) begin
        check("in_ready_after_accept", 32'(in_ready), 32'd1);
        check("out_valid_fell", 32'(out_valid), 32'd0);
        accepted_last = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          cur = sb[0];
          if (!prev_valid) begin
            check($sformatf("latency_a%0d", cur.a), 32'(cyc - cur.acc), 32'(cur.lat));
            if (!hold_used) begin
              hold_used = 1'b1;
              hold_left = 10;
            end
          end
          check($sformatf("x_deg_a%0d", cur.a), x_deg, cur.x);
          check($sformatf("neg_a%0d", cur.a), 32'(neg), 32'(cur.sgn));
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else begin
            out_ready = ($urandom_range(0, 3) != 0);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            accepted_last = 1'b1;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      prev_valid = out_valid;
    end
  end

  initial begin : driver
    int unsigned dir[$];
    int t;
    rst      = 1'b1;
    in_valid = 1'b0;
    angle    = '0;
    repeat (2) @(negedge clk);
    check("rst_x_deg", x_deg, 32'h0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Abort an operand mid-reduction; it must never produce a result.
    send(1000, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_x_deg", x_deg, 32'h0);
    check("abort_neg", 32'(neg), 32'd0);

    dir = '{26, 60, 386, 200, 90, 180, 270, 65535, 0, 359, 360, 91, 181, 271, 1, 64, 63, 720};
    foreach (dir[i]) send(dir[i], 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) send($urandom_range(0, 65535), 1'b1);
      else            send($urandom_range(0, 1500), 1'b1);
    end

    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
